// File: rtl/vid_frame_sequencer.sv
// vid_frame_sequencer: raster timing generator emitting AXI4-Stream video with SOF/EOL sideband
module vid_frame_sequencer #(
  parameter int H_ACTIVE  = 640,
  parameter int H_B_PORCH = 120,
  parameter int H_F_PORCH = 200,
  parameter int V_ACTIVE  = 480,
  parameter int V_B_PORCH = 120,
  parameter int V_F_PORCH = 100
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        err_clr,
  output logic        pix_req,
  input  logic [15:0] pix_in,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [15:0] hcnt,
  output logic [15:0] vcnt,
  output logic [31:0] frame_cnt,
  output logic [15:0] line_no,
  output logic        frame_done,
  output logic        busy,
  output logic        ovf_err
);
  localparam int H_TOT = H_B_PORCH + H_ACTIVE + H_F_PORCH;
  localparam int V_TOT = V_B_PORCH + V_ACTIVE + V_F_PORCH;
  localparam logic [15:0] H_LAST = 16'(H_TOT - 1);
  localparam logic [15:0] V_LAST = 16'(V_TOT - 1);
  localparam logic [15:0] H_A0   = 16'(H_B_PORCH);
  localparam logic [15:0] H_A1   = 16'(H_B_PORCH + H_ACTIVE);
  localparam logic [15:0] H_AL   = 16'(H_B_PORCH + H_ACTIVE - 1);
  localparam logic [15:0] V_A0   = 16'(V_B_PORCH);
  localparam logic [15:0] V_A1   = 16'(V_B_PORCH + V_ACTIVE);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      r_state;
  logic [15:0] r_hcnt, r_vcnt, r_line_no, r_tdata;
  logic [31:0] r_frame_cnt;
  logic        r_frame_done, r_req_d1, r_user_d1, r_last_d1;
  logic        r_tvalid, r_tuser, r_tlast, r_ovf;
  logic        w_run, w_h_end, w_frame_end;

  assign w_run       = r_state != IDLE;
  assign w_h_end     = r_hcnt == H_LAST;
  assign w_frame_end = w_run && w_h_end && r_vcnt == V_LAST;
  assign pix_req     = w_run && r_hcnt >= H_A0 && r_hcnt < H_A1 && r_vcnt >= V_A0 && r_vcnt < V_A1;

  // Raster FSM: counters sweep the whole frame in RUN/DRAIN; DRAIN finishes the frame then parks in IDLE
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      r_state      <= IDLE;
      r_hcnt       <= 16'd0;
      r_vcnt       <= 16'd0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= 32'd0;
    end else begin
      r_state      <= enable ? RUN : (!w_run || w_frame_end) ? IDLE : DRAIN;
      r_hcnt       <= (w_run && !w_h_end) ? r_hcnt + 16'd1 : 16'd0;
      r_vcnt       <= !w_run ? 16'd0 : !w_h_end ? r_vcnt : (r_vcnt == V_LAST) ? 16'd0 : r_vcnt + 16'd1;
      r_frame_done <= w_frame_end;
      r_frame_cnt  <= r_frame_cnt + 32'(w_frame_end);
    end

  // Two-stage sideband delay so flags line up with pix_in arriving one cycle after the request
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      r_req_d1  <= 1'b0;
      r_user_d1 <= 1'b0;
      r_last_d1 <= 1'b0;
      r_tvalid  <= 1'b0;
      r_tuser   <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= 16'd0;
    end else begin
      r_req_d1  <= pix_req;
      r_user_d1 <= pix_req && r_hcnt == H_A0 && r_vcnt == V_A0;
      r_last_d1 <= pix_req && r_hcnt == H_AL;
      r_tvalid  <= r_req_d1;
      r_tuser   <= r_user_d1;
      r_tlast   <= r_last_d1;
      r_tdata   <= r_req_d1 ? pix_in : 16'd0;
    end

  // Status: sticky overflow on a refused beat (set beats clear), active line count of accepted beats
  always_ff @(posedge pclk or posedge rst)
    if (rst) begin
      r_ovf     <= 1'b0;
      r_line_no <= 16'd0;
    end else begin
      r_ovf <= (r_tvalid && !m_axis_tready) || (r_ovf && !err_clr);
      if (r_tvalid && m_axis_tready)
        r_line_no <= (r_tuser ? 16'd0 : r_line_no) + 16'(r_tlast);
    end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;
  assign hcnt          = r_hcnt;
  assign vcnt          = r_vcnt;
  assign frame_cnt     = r_frame_cnt;
  assign line_no       = r_line_no;
  assign frame_done    = r_frame_done;
  assign busy          = w_run || r_req_d1 || r_tvalid;
  assign ovf_err       = r_ovf;
endmodule

// File: tb/tb_vid_frame_sequencer.sv
// tb_vid_frame_sequencer: directed checks of raster timing, stream sideband, drain, overflow and reset
module tb_vid_frame_sequencer;
  logic        pclk = 1'b0;
  logic        rst = 1'b1, enable = 1'b0, err_clr = 1'b0, m_axis_tready = 1'b1;
  logic [15:0] pix_in;
  logic        pix_req, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, busy, ovf_err;
  logic [15:0] m_axis_tdata, hcnt, vcnt, line_no;
  logic [31:0] frame_cnt;
  logic        src_req;
  logic [15:0] ramp;
  int          total = 0, bad = 0;

  always #5 pclk = ~pclk;

  vid_frame_sequencer #(
    .H_ACTIVE(4), .H_B_PORCH(2), .H_F_PORCH(1),
    .V_ACTIVE(3), .V_B_PORCH(1), .V_F_PORCH(1)
  ) dut (
    .pclk(pclk), .rst(rst), .enable(enable), .err_clr(err_clr),
    .pix_req(pix_req), .pix_in(pix_in),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .hcnt(hcnt), .vcnt(vcnt), .frame_cnt(frame_cnt), .line_no(line_no),
    .frame_done(frame_done), .busy(busy), .ovf_err(ovf_err)
  );

  // frame source: answers each request with the next ramp value during the following cycle
  initial begin
    pix_in = 16'd0;
    ramp = 16'd0;
    forever begin
      @(negedge pclk);
      src_req = pix_req;
      @(posedge pclk);
      #1;
      if (rst) begin
        ramp = 16'd0;
        pix_in = 16'd0;
      end else if (src_req) begin
        pix_in = ramp;
        ramp = ramp + 16'd1;
      end
    end
  end

  task automatic do_reset;
    rst = 1'b1;
    enable = 1'b0;
    err_clr = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge pclk);
    total++;
    if ({pix_req, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, busy, ovf_err} !== 7'd0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0", {pix_req, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, busy, ovf_err});
    end
    total++;
    if ({m_axis_tdata, hcnt, vcnt, line_no, frame_cnt} !== 96'd0) begin
      bad++;
      $display("FAIL reset_counts got=%h want=0", {m_axis_tdata, hcnt, vcnt, line_no, frame_cnt});
    end
    rst = 1'b0;
    repeat (4) @(negedge pclk);
    total++;
    if ({busy, pix_req, hcnt, vcnt} !== 34'd0) begin
      bad++;
      $display("FAIL idle_hold got=%h want=0", {busy, pix_req, hcnt, vcnt});
    end
  endtask

  task automatic test_frame;
    int cc, h, v, seq;
    logic e_req, e_val;
    do_reset();
    enable = 1'b1;
    seq = 0;
    for (int c = 0; c <= 70; c++) begin
      @(negedge pclk);
      cc = c % 35;
      h = cc % 7;
      v = cc / 7;
      e_req = h >= 2 && h <= 5 && v >= 1 && v <= 3;
      e_val = cc >= 11 && cc <= 28 && (cc - 11) % 7 < 4;
      total++;
      if ({hcnt, vcnt} !== {16'(h), 16'(v)}) begin
        bad++;
        $display("FAIL frame_pos c=%0d got=%0d,%0d want=%0d,%0d", c, hcnt, vcnt, h, v);
      end
      total++;
      if (pix_req !== e_req) begin
        bad++;
        $display("FAIL frame_req c=%0d got=%b want=%b", c, pix_req, e_req);
      end
      total++;
      if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast} !== {e_val, cc == 11, cc == 14 || cc == 21 || cc == 28}) begin
        bad++;
        $display("FAIL frame_vul c=%0d got=%b want=%b", c, {m_axis_tvalid, m_axis_tuser, m_axis_tlast},
                 {e_val, cc == 11, cc == 14 || cc == 21 || cc == 28});
      end
      total++;
      if ({frame_done, frame_cnt} !== {cc == 0 && c > 0, 32'(c / 35)}) begin
        bad++;
        $display("FAIL frame_done c=%0d got=%b/%0d want=%b/%0d", c, frame_done, frame_cnt, cc == 0 && c > 0, c / 35);
      end
      if (e_val) begin
        total++;
        if (m_axis_tdata !== 16'(seq)) begin
          bad++;
          $display("FAIL frame_data c=%0d got=%h want=%h", c, m_axis_tdata, 16'(seq));
        end
        seq++;
      end
      if (c == 35 || c == 70 || c == 47) begin
        total++;
        if (line_no !== (c == 47 ? 16'd0 : 16'd3)) begin
          bad++;
          $display("FAIL frame_line c=%0d got=%0d want=%0d", c, line_no, c == 47 ? 0 : 3);
        end
      end
    end
    total++;
    if (seq != 24) begin
      bad++;
      $display("FAIL frame_beats got=%0d want=24", seq);
    end
  endtask

  task automatic test_drain;
    int h, v, beats;
    logic e_req;
    do_reset();
    enable = 1'b1;
    beats = 0;
    for (int c = 0; c <= 55; c++) begin
      @(negedge pclk);
      h = c % 7;
      v = c / 7;
      e_req = c < 35 && h >= 2 && h <= 5 && v >= 1 && v <= 3;
      if (m_axis_tvalid === 1'b1) beats++;
      total++;
      if ({pix_req, busy, frame_done} !== {e_req, c < 35, c == 35}) begin
        bad++;
        $display("FAIL drain c=%0d got=%b want=%b", c, {pix_req, busy, frame_done}, {e_req, c < 35, c == 35});
      end
      if (c >= 35) begin
        total++;
        if ({hcnt, vcnt} !== 32'd0) begin
          bad++;
          $display("FAIL drain_idle c=%0d got=%0d,%0d want=0,0", c, hcnt, vcnt);
        end
      end
      if (c == 15) enable = 1'b0;
    end
    total++;
    if (beats != 12 || frame_cnt !== 32'd1) begin
      bad++;
      $display("FAIL drain_total got=%0d/%0d want=12/1", beats, frame_cnt);
    end
  endtask

  task automatic test_overflow;
    int h, v;
    logic e_req;
    do_reset();
    enable = 1'b1;
    for (int c = 0; c <= 35; c++) begin
      @(negedge pclk);
      h = c % 7;
      v = c / 7;
      e_req = h >= 2 && h <= 5 && v >= 1 && v <= 3;
      total++;
      if ({ovf_err, pix_req} !== {c >= 13 && c <= 22, e_req}) begin
        bad++;
        $display("FAIL ovf c=%0d got=%b want=%b", c, {ovf_err, pix_req}, {c >= 13 && c <= 22, e_req});
      end
      m_axis_tready = !(c == 12 || c == 18);
      err_clr = c == 18 || c == 22;
    end
    total++;
    if ({frame_done, line_no} !== {1'b1, 16'd3}) begin
      bad++;
      $display("FAIL ovf_end got=%b/%0d want=1/3", frame_done, line_no);
    end
    m_axis_tready = 1'b1;
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid;
    int h, v;
    logic e_val;
    do_reset();
    enable = 1'b1;
    repeat (21) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    total++;
    if ({pix_req, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, busy, ovf_err} !== 7'd0) begin
      bad++;
      $display("FAIL rstmid_flags got=%b want=0", {pix_req, m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, busy, ovf_err});
    end
    total++;
    if ({m_axis_tdata, hcnt, vcnt, line_no, frame_cnt} !== 96'd0) begin
      bad++;
      $display("FAIL rstmid_counts got=%h want=0", {m_axis_tdata, hcnt, vcnt, line_no, frame_cnt});
    end
    rst = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      @(negedge pclk);
      h = c % 7;
      v = c / 7;
      e_val = c >= 11;
      total++;
      if ({hcnt, vcnt, m_axis_tvalid} !== {16'(h), 16'(v), e_val}) begin
        bad++;
        $display("FAIL restart c=%0d got=%0d,%0d,%b want=%0d,%0d,%b", c, hcnt, vcnt, m_axis_tvalid, h, v, e_val);
      end
      if (c == 11) begin
        total++;
        if ({m_axis_tuser, m_axis_tdata} !== {1'b1, 16'd0}) begin
          bad++;
          $display("FAIL restart_sof got=%b/%h want=1/0000", m_axis_tuser, m_axis_tdata);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_drain();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
